// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing block.
//   - default 800x480 timing constants
//   - phase_t: per-axis timing phase
//   - phase_of(): phase for a counter value, given the four axis boundaries
package vga_pkg;

  localparam int unsigned HDISP_DEF  = 800;
  localparam int unsigned HFP_DEF    = 40;
  localparam int unsigned HPULSE_DEF = 48;
  localparam int unsigned HBP_DEF    = 40;
  localparam int unsigned VDISP_DEF  = 480;
  localparam int unsigned VFP_DEF    = 13;
  localparam int unsigned VPULSE_DEF = 3;
  localparam int unsigned VBP_DEF    = 29;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } phase_t;

  // Boundaries are the counts at which FRONT, SYNC, BACK and the next ACTIVE begin.
  function automatic phase_t phase_of(input int unsigned cnt,
                                      input int unsigned disp_end,
                                      input int unsigned fp_end,
                                      input int unsigned sync_end,
                                      input int unsigned total);
    phase_t p;
    if (cnt < disp_end)      p = ACTIVE;
    else if (cnt < fp_end)   p = FRONT;
    else if (cnt < sync_end) p = SYNC;
    else if (cnt < total)    p = BACK;
    else                     p = ACTIVE;
    return p;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a 0..TOTAL-1 counter plus its phase register.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   tick     : advance by one count
//   cnt      : current count
//   phase    : phase of the current count (ACTIVE/FRONT/SYNC/BACK)
//   wrap     : tick while cnt is TOTAL-1 (counter returns to 0 on this tick)
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned DISP  = HDISP_DEF,
  parameter int unsigned FP    = HFP_DEF,
  parameter int unsigned PULSE = HPULSE_DEF,
  parameter int unsigned BP    = HBP_DEF,
  localparam int unsigned TOTAL = DISP + FP + PULSE + BP,
  localparam int unsigned W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  output logic [W-1:0] cnt,
  output phase_t       phase,
  output logic         wrap
);

  logic   [W-1:0] cnt_d;
  logic           at_end;
  phase_t         phase_d;

  always_comb begin
    at_end  = (cnt == W'(TOTAL - 1));
    wrap    = tick && at_end;
    cnt_d   = at_end ? '0 : cnt + W'(1);
    // Phase is registered alongside the count so it always describes cnt.
    phase_d = phase_of(32'(cnt_d), DISP, DISP + FP, DISP + FP + PULSE, TOTAL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= ACTIVE;
    end else if (tick) begin
      cnt   <= cnt_d;
      phase <= phase_d;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA timing and output stage.
// Counts H/V position, issues pixel coordinates upstream, and re-aligns the returned RGB
// with sync and blank delayed by LATENCY enabled cycles. All outputs are registered.
// Ports:
//   CLK, RST       : clock, asynchronous active-high reset
//   PIX_EN         : pixel-clock enable; all state advances only when high
//   RGB_IN         : upstream pixel {R,G,B}, valid LATENCY enabled cycles after PIX_X/PIX_Y
//   PIX_X, PIX_Y   : requested coordinate (also counts through blanking)
//   PIX_REQ        : requested coordinate lies in the active area
//   FRAME_START    : coordinate is (0,0)
//   VGA_R/G/B      : output colour, zero outside the active area
//   VGA_HS, VGA_VS : active-low syncs
//   VGA_BLANK      : active-low blank (high in the active area)
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned HDISP   = HDISP_DEF,
  parameter int unsigned HFP     = HFP_DEF,
  parameter int unsigned HPULSE  = HPULSE_DEF,
  parameter int unsigned HBP     = HBP_DEF,
  parameter int unsigned VDISP   = VDISP_DEF,
  parameter int unsigned VFP     = VFP_DEF,
  parameter int unsigned VPULSE  = VPULSE_DEF,
  parameter int unsigned VBP     = VBP_DEF,
  parameter int unsigned LATENCY = 2
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic                                         PIX_EN,
  input  logic [23:0]                                  RGB_IN,
  output logic [$clog2(HDISP+HFP+HPULSE+HBP)-1:0]      PIX_X,
  output logic [$clog2(VDISP+VFP+VPULSE+VBP)-1:0]      PIX_Y,
  output logic                                         PIX_REQ,
  output logic                                         FRAME_START,
  output logic [7:0]                                   VGA_R,
  output logic [7:0]                                   VGA_G,
  output logic [7:0]                                   VGA_B,
  output logic                                         VGA_HS,
  output logic                                         VGA_VS,
  output logic                                         VGA_BLANK
);

  localparam int unsigned HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int unsigned VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int unsigned XW     = $clog2(HTOTAL);
  localparam int unsigned YW     = $clog2(VTOTAL);

  logic [XW-1:0] hcnt;
  logic [YW-1:0] vcnt;
  phase_t        hphase;
  phase_t        vphase;
  logic          hwrap;
  logic          vwrap;
  logic          vtick;

  assign vtick = hwrap && PIX_EN;

  vga_axis_counter #(
    .DISP  (HDISP),
    .FP    (HFP),
    .PULSE (HPULSE),
    .BP    (HBP)
  ) u_hcnt (
    .clk   (CLK),
    .rst   (RST),
    .tick  (PIX_EN),
    .cnt   (hcnt),
    .phase (hphase),
    .wrap  (hwrap)
  );

  vga_axis_counter #(
    .DISP  (VDISP),
    .FP    (VFP),
    .PULSE (VPULSE),
    .BP    (VBP)
  ) u_vcnt (
    .clk   (CLK),
    .rst   (RST),
    .tick  (vtick),
    .cnt   (vcnt),
    .phase (vphase),
    .wrap  (vwrap)
  );

  // The vertical counter can only wrap on the last tick of a line.
  a_vwrap_on_hwrap : assert property (@(posedge CLK) disable iff (RST) vwrap |-> hwrap);

  // Stage 0: coordinate issue, plus sync levels for the same coordinate.
  logic hs0;
  logic vs0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PIX_X       <= '0;
      PIX_Y       <= '0;
      PIX_REQ     <= 1'b0;
      FRAME_START <= 1'b0;
      hs0         <= 1'b1;
      vs0         <= 1'b1;
    end else if (PIX_EN) begin
      PIX_X       <= hcnt;
      PIX_Y       <= vcnt;
      PIX_REQ     <= (hphase == ACTIVE) && (vphase == ACTIVE);
      FRAME_START <= (hcnt == '0) && (vcnt == '0);
      hs0         <= (hphase != SYNC);
      vs0         <= (vphase != SYNC);
    end
  end

  // Delay line {req, hs, vs} matching the upstream pixel latency.
  logic req_dly;
  logic hs_dly;
  logic vs_dly;

  if (LATENCY == 0) begin : g_no_delay
    assign {req_dly, hs_dly, vs_dly} = {PIX_REQ, hs0, vs0};
  end else begin : g_delay
    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      logic [2:0] q;
      logic [2:0] d;
      if (i == 0) begin : g_first
        assign d = {PIX_REQ, hs0, vs0};
      end else begin : g_next
        assign d = g_stage[i-1].q;
      end
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)         q <= 3'b011;
        else if (PIX_EN) q <= d;
      end
    end
    assign {req_dly, hs_dly, vs_dly} = g_stage[LATENCY-1].q;
  end

  // Output register: colour gated by the delayed request so blank and RGB line up.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_BLANK <= 1'b0;
    end else if (PIX_EN) begin
      {VGA_R, VGA_G, VGA_B} <= req_dly ? RGB_IN : 24'h0;
      VGA_HS                <= hs_dly;
      VGA_VS                <= vs_dly;
      VGA_BLANK             <= req_dly;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three DUTs (LATENCY 0, 2, 8) on a reduced raster share one stimulus.
// Each DUT has an upstream pixel model, a producer that queues the expected outputs for each
// enabled edge, and a monitor that pops and compares on the falling edge.
module tb_vga_timing;

  localparam int HD = 16;
  localparam int HF = 3;
  localparam int HP = 4;
  localparam int HB = 5;
  localparam int VD = 10;
  localparam int VF = 2;
  localparam int VP = 2;
  localparam int VB = 3;
  localparam int HT = HD + HF + HP + HB;
  localparam int VT = VD + VF + VP + VB;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          req;
    logic          fs;
    logic          hs;
    logic          vs;
    logic          blank;
    logic [23:0]   rgb;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  // Expected pins after the k-th enabled edge since reset release.
  function automatic obs_t model(input int k, input int lat);
    obs_t o;
    int   h, v, j, hj, vj;
    logic act;
    o     = reset_obs();
    h     = k % HT;
    v     = (k / HT) % VT;
    o.x   = XW'(h);
    o.y   = YW'(v);
    o.req = (h < HD) && (v < VD);
    o.fs  = (k % (HT * VT)) == 0;
    j     = k - (lat + 1);
    if (j >= 0) begin
      hj      = j % HT;
      vj      = (j / HT) % VT;
      act     = (hj < HD) && (vj < VD);
      o.hs    = !((hj >= HD + HF) && (hj < HD + HF + HP));
      o.vs    = !((vj >= VD + VF) && (vj < VD + VF + VP));
      o.blank = act;
      o.rgb   = act ? {8'(hj), 8'(vj), 8'hA5} : 24'h0;
    end
    return o;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : (g == 1) ? 2 : 8;

    logic [XW-1:0]    px;
    logic [YW-1:0]    py;
    logic             preq, fs, hs, vs, blank;
    logic [7:0]       r, gr, b;
    logic [23:0]      rgb_in;
    logic [XW+YW-1:0] hist [0:8];
    obs_t             cur;
    obs_t             last;
    obs_t             q [$];
    int               k;
    logic             en_seen;

    vga_timing #(
      .HDISP   (HD),
      .HFP     (HF),
      .HPULSE  (HP),
      .HBP     (HB),
      .VDISP   (VD),
      .VFP     (VF),
      .VPULSE  (VP),
      .VBP     (VB),
      .LATENCY (L)
    ) dut (
      .CLK         (clk),
      .RST         (rst),
      .PIX_EN      (pix_en),
      .RGB_IN      (rgb_in),
      .PIX_X       (px),
      .PIX_Y       (py),
      .PIX_REQ     (preq),
      .FRAME_START (fs),
      .VGA_R       (r),
      .VGA_G       (gr),
      .VGA_B       (b),
      .VGA_HS      (hs),
      .VGA_VS      (vs),
      .VGA_BLANK   (blank)
    );

    assign cur = {px, py, preq, fs, hs, vs, blank, r, gr, b};

    // Upstream source: returns {X,Y,A5} for the coordinate issued L enabled cycles ago.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 9; i++) hist[i] <= '0;
      end else if (pix_en) begin
        hist[0] <= {px, py};
        for (int i = 1; i < 9; i++) hist[i] <= hist[i-1];
      end
    end

    if (L == 0) begin : g_up0
      assign rgb_in = {8'(px), 8'(py), 8'hA5};
    end else begin : g_upn
      assign rgb_in = {8'(hist[L-1][XW+YW-1:YW]), 8'(hist[L-1][YW-1:0]), 8'hA5};
    end

    // Producer: one expected record per enabled edge.
    initial begin
      k       = 0;
      en_seen = 1'b0;
      forever begin
        @(posedge clk);
        en_seen = !rst && pix_en;
        if (rst) begin
          q.delete();
          k = 0;
        end else if (pix_en) begin
          q.push_back(model(k, L));
          k++;
        end
      end
    end

    // Monitor: compare after every edge; disabled edges must leave the pins unchanged.
    initial begin
      last = reset_obs();
      forever begin
        @(negedge clk);
        if (rst) begin
          last = reset_obs();
        end else if (en_seen) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL lat=%0d expect_queue_empty got=%h", L, cur);
          end else begin
            last = q.pop_front();
            if (cur !== last) begin
              fails++;
              $display("FAIL lat=%0d enabled_edge got=%h expected=%h", L, cur, last);
            end
          end
        end else begin
          tests++;
          if (cur !== last) begin
            fails++;
            $display("FAIL lat=%0d hold_edge got=%h expected=%h", L, cur, last);
          end
        end
      end
    end

    // Asynchronous reset must reach the pins without waiting for a clock.
    initial begin
      forever begin
        @(posedge rst);
        #1;
        tests++;
        if (cur !== reset_obs()) begin
          fails++;
          $display("FAIL lat=%0d async_reset got=%h expected=%h", L, cur, reset_obs());
        end
      end
    end
  end

  task automatic drive(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      case (mode)
        0:       pix_en = 1'b1;
        1:       pix_en = i[0];
        default: pix_en = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  initial begin
    bit found;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    drive(2 * HT * VT + 40, 0);
    drive(1000, 1);
    drive(1200, 2);

    // Reset mid-frame at the centre of the active area.
    found = 1'b0;
    for (int n = 0; n < 2 * HT * VT && !found; n++) begin
      @(negedge clk);
      #1;
      pix_en = 1'b1;
      if (g_dut[1].px == XW'(HD / 2) && g_dut[1].py == YW'(VD / 2)) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL reset_point_not_reached got=%h,%h", g_dut[1].px, g_dut[1].py);
    end
    rst = 1'b1;
    drive(2, 2);
    rst = 1'b0;
    drive(HT * VT + 30, 2);
    drive(HT * VT, 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=stuck expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Video timing and output stage for the display path. Generates horizontal/vertical counters, requests pixels from the upstream pattern/frame source by coordinate, and re-aligns the returned RGB with sync and blanking delayed by a fixed pipeline latency. Instantiated by the `fpga` top level; drives the DAC/VGA pins directly.

## Interface

**Parameters**
- `HDISP`, default 800: active pixels per line.
- `HFP`, default 40: horizontal front porch, in pixels.
- `HPULSE`, default 48: HS pulse width.
- `HBP`, default 40: horizontal back porch.
- `VDISP`, default 480: active lines.
- `VFP`, default 13: vertical front porch, in lines.
- `VPULSE`, default 3: VS pulse width.
- `VBP`, default 29: vertical back porch.
- `LATENCY`, default 2: enabled cycles from `PIX_X`/`PIX_Y` to valid `RGB_IN`. Legal range 0..8.

**Ports**
- `CLK` in 1: the single clock.
- `RST` in 1: asynchronous reset, active-high.
- `PIX_EN` in 1: pixel-clock enable. All state advances only when this is high.
- `RGB_IN` in 24: upstream pixel, packed {R[7:0],G[7:0],B[7:0]}.
- `PIX_X` out $clog2(HTOTAL): requested column.
- `PIX_Y` out $clog2(VTOTAL): requested line.
- `PIX_REQ` out 1: requested coordinate is inside the active area.
- `FRAME_START` out 1: high for one enabled cycle with (0,0).
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: output colour.
- `VGA_HS` out 1: horizontal sync, active-low.
- `VGA_VS` out 1: vertical sync, active-low.
- `VGA_BLANK` out 1: active-low blank, high during the active area.

## Operation

- Totals: HTOTAL = HDISP+HFP+HPULSE+HBP = 928; VTOTAL = VDISP+VFP+VPULSE+VBP = 525.
- `hcnt` runs 0..HTOTAL-1 and wraps to 0.
- `vcnt` increments only when `hcnt` wraps, and wraps to 0 after VTOTAL-1.
- Per-axis phase FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE. Transitions occur at counter boundaries: HDISP, HDISP+HFP, HDISP+HFP+HPULSE, HTOTAL (and the V equivalents).
- HS is low while the H phase is SYNC. VS is low while the V phase is SYNC.
- Stage 0 registers on each `PIX_EN`, loaded from the current counters:
  - `PIX_X` ← `hcnt`, `PIX_Y` ← `vcnt`.
  - `PIX_REQ` ← both phases ACTIVE.
  - `FRAME_START` ← (`hcnt`==0 && `vcnt`==0).
  - Internal hs0/vs0 are loaded the same way.
- `PIX_X`/`PIX_Y` also count during blanking. Upstream ignores them when `PIX_REQ`=0.
- Delay line: `PIX_REQ`, hs0 and vs0 are shifted LATENCY enabled stages.
- Output register, on `PIX_EN`:
  - `VGA_R/G/B` ← `RGB_IN` if the delayed req is 1, else 0.
  - `VGA_HS`, `VGA_VS`, `VGA_BLANK` ← delayed hs, vs, req.
- Reset (asynchronous, any time, including mid-line):
  - counters 0, both phases ACTIVE;
  - `PIX_X`=0, `PIX_Y`=0, `PIX_REQ`=0, `FRAME_START`=0;
  - delay line cleared to req=0, hs=1, vs=1;
  - `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK`=0, RGB=0.
- `PIX_EN` low: every register holds, and pulses are not regenerated or stretched. `FRAME_START` remains as registered but is qualified by `PIX_EN` at the consumer.
- Both counters wrapping on the same cycle (end of frame): the next enabled cycle yields `FRAME_START`=1 with (0,0).

## Timing

- Coordinate latency: 1 enabled cycle from the counter to `PIX_X`/`PIX_Y`/`PIX_REQ`.
- Video latency: `VGA_*` reflects the coordinate issued LATENCY+1 enabled cycles earlier.
- Sync/blank/RGB skew is zero on the pins.
- First enabled cycle after reset release gives `PIX_X`=0, `PIX_Y`=0, `PIX_REQ`=1, `FRAME_START`=1.
- `VGA_BLANK` first goes high LATENCY+1 enabled cycles after that.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- `vga_pkg`:
  - default timing constants;
  - `phase_t` enum {ACTIVE, FRONT, SYNC, BACK};
  - a function returning the phase for a count and the four boundaries.
- Sub-module `vga_axis_counter`: parameterized counter plus phase FSM with a `tick` input and `wrap` output. Instantiated twice:
  - H axis: `tick`=`PIX_EN`;
  - V axis: `tick`=H `wrap`&&`PIX_EN`.
- Delay line is a generate loop of LATENCY register stages. With LATENCY=0 it is a wire.

## Test plan

- Reset, `PIX_EN`=1 constant, default parameters → `FRAME_START` period is 928×525 = 487200 cycles; `PIX_REQ` high for 800 consecutive cycles per line, 480 lines per frame.
- Sync positions → `VGA_HS` low exactly 48 cycles starting at X=840 (delayed LATENCY+1); `VGA_VS` low for 3 lines starting at line 493; edges aligned with H wrap.
- Upstream model returns `RGB_IN`={X[7:0],Y[7:0],8'hA5} after LATENCY=2 → every active pin pixel matches its coordinate; RGB=0 whenever `VGA_BLANK`=0.
- `PIX_EN` toggled 1-of-2 and random → identical output sequence per enabled cycle versus the `PIX_EN`=1 run.
- `RST` asserted at X=400, Y=200 → all outputs immediately at reset values; after release, stream restarts at (0,0) with `FRAME_START`=1.
- LATENCY=0 and LATENCY=8 builds → blank/RGB alignment holds; HTOTAL boundary X=927→0 wraps and increments Y.
